// File: rtl/tetris_pkg.sv
// tetris_pkg: shared state codes, rotation mask and LFSR helper for the game sequencer
package tetris_pkg;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPAWN = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_FALL  = 3'd3;
    localparam logic [2:0] S_LOCK  = 3'd4;
    localparam logic [2:0] S_OVER  = 3'd5;
    localparam logic [1:0] ROT_MASK = 2'b11;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/key_edge.sv
// key_edge: rising-edge detector with a pending latch that holds until cleared or disabled
module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    input  logic en_i,
    input  logic clr_i,
    output logic pend_o
);
    logic prev_q, pend_q, pend_d;
    assign pend_d = en_i && ((pend_q && !clr_i) || (key_i && !prev_q));
    assign pend_o = pend_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= key_i;
            pend_q <= pend_d;
        end
    end
endmodule

// File: rtl/tetris_game_ctrl.sv
// tetris_game_ctrl: spawns pieces, turns keys and gravity into move pulses, times locks and keeps score
module tetris_game_ctrl
    import tetris_pkg::*;
#(
    parameter int          GRAVITY_DIV = 50_000_000,
    parameter int          LOCK_CYCLES = 2,
    parameter int          NUM_BLOCKS  = 7,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_down,
    input  logic        key_rot,
    input  logic        next_block,
    input  logic        field_over,
    input  logic [9:0]  score_plus,
    output logic        left,
    output logic        right,
    output logic        down,
    output logic [9:0]  ro,
    output logic [9:0]  block_num,
    output logic [15:0] score,
    output logic        playing,
    output logic        game_over
);
    localparam int GW = $clog2(GRAVITY_DIV);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    logic [2:0]    state_q, state_d;
    logic [GW-1:0] grav_q, grav_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [15:0]   lfsr_q, score_q, score_d;
    logic [16:0]   sum;
    logic [1:0]    ro_q, ro_d;
    logic [9:0]    block_q, block_d;
    logic          left_q, right_q, down_q, lock_last;
    logic          in_fall, decide, grav_req;
    logic          p_rot, p_left, p_right, p_down;
    logic          i_rot, i_left, i_right, i_down;
    assign in_fall   = state_q == S_FALL;
    assign decide    = in_fall && !next_block;
    assign grav_req  = in_fall && grav_q == GW'(GRAVITY_DIV - 1);
    assign i_rot     = decide && !grav_req && p_rot;
    assign i_left    = decide && !grav_req && !p_rot && p_left;
    assign i_right   = decide && !grav_req && !p_rot && !p_left && p_right;
    assign i_down    = decide && !grav_req && !p_rot && !p_left && !p_right && p_down;
    assign sum       = {1'b0, score_q} + {7'b0, score_plus};
    assign lock_last = lock_q == LW'(LOCK_CYCLES - 1);
    key_edge u_rot   (.clk(clk), .rst(rst), .key_i(key_rot),   .en_i(in_fall), .clr_i(i_rot),   .pend_o(p_rot));
    key_edge u_left  (.clk(clk), .rst(rst), .key_i(key_left),  .en_i(in_fall), .clr_i(i_left),  .pend_o(p_left));
    key_edge u_right (.clk(clk), .rst(rst), .key_i(key_right), .en_i(in_fall), .clr_i(i_right), .pend_o(p_right));
    key_edge u_down  (.clk(clk), .rst(rst), .key_i(key_down),  .en_i(in_fall), .clr_i(i_down),  .pend_o(p_down));
    always_comb begin
        state_d = state_q;
        grav_d  = grav_q;
        lock_d  = lock_q;
        score_d = score_q;
        ro_d    = ro_q;
        block_d = block_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_SPAWN : S_IDLE;
            S_SPAWN: begin
                state_d = S_CHECK;
                block_d = 10'(lfsr_q % 16'(NUM_BLOCKS));
                ro_d    = 2'd0;
                grav_d  = '0;
            end
            S_CHECK: state_d = field_over ? S_OVER : S_FALL;
            S_FALL: begin
                grav_d  = grav_req ? '0 : grav_q + 1'b1;
                state_d = next_block ? S_LOCK : S_FALL;
                ro_d    = i_rot ? (ro_q + 2'd1) & ROT_MASK : ro_q;
            end
            S_LOCK: begin
                score_d = lock_q == '0 ? (sum[16] ? 16'hFFFF : sum[15:0]) : score_q;
                lock_d  = lock_last ? '0 : lock_q + 1'b1;
                state_d = lock_last ? S_SPAWN : S_LOCK;
            end
            S_OVER: begin
                score_d = start ? 16'd0 : score_q;
                state_d = start ? S_SPAWN : S_OVER;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grav_q  <= '0;
            lock_q  <= '0;
            score_q <= 16'd0;
            ro_q    <= 2'd0;
            block_q <= 10'd0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            down_q  <= 1'b0;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            grav_q  <= grav_d;
            lock_q  <= lock_d;
            score_q <= score_d;
            ro_q    <= ro_d;
            block_q <= block_d;
            left_q  <= i_left;
            right_q <= i_right;
            down_q  <= (decide && grav_req) || i_down;
            lfsr_q  <= lfsr_next(lfsr_q);
        end
    end
    assign left      = left_q;
    assign right     = right_q;
    assign down      = down_q;
    assign ro        = {8'd0, ro_q};
    assign block_num = block_q;
    assign score     = score_q;
    assign playing   = state_q inside {S_SPAWN, S_CHECK, S_FALL, S_LOCK};
    assign game_over = state_q == S_OVER;
endmodule
